vx_mem_req_arbiter: RTL and testbench

Shares one data-cache request port among NUM_REQS requesters (e.g. LSU lanes, shared-memory unit) using round-robin arbitration with a registered output stage. It extends the outgoing tag with the requester index and routes responses back by that index. It enforces a per-requester limit on outstanding reads and exposes pending-read counts for the core perf counters. It sits between the execute stage and the core dcache bus.

---
 rtl/vx_mem_req_arbiter_if.sv | 69 ++++++
 rtl/vx_mem_req_arbiter.sv | 177 +++++++++++++++++
 tb/tb_vx_mem_req_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vx_mem_req_arbiter_if.sv
// Bus bundle between the requesters, the arbiter and the dcache port.
//
// Every valid/ready pair below follows the same rule: a transfer fires on a
// rising clk edge where valid and ready are both high; a source holds valid
// and its payload stable until that edge; ready may depend combinationally
// on valid; valid never depends on ready.
interface vx_mem_req_arbiter_if #(
  parameter int NUM_REQS   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 8
);
  localparam int SEL_W = $clog2(NUM_REQS);
  localparam int BE_W  = DATA_WIDTH / 8;

  // requester side
  logic [NUM_REQS-1:0]            req_valid_in;
  logic [NUM_REQS-1:0]            req_rw_in;
  logic [NUM_REQS*ADDR_WIDTH-1:0] req_addr_in;
  logic [NUM_REQS*DATA_WIDTH-1:0] req_data_in;
  logic [NUM_REQS*BE_W-1:0]       req_byteen_in;
  logic [NUM_REQS*TAG_WIDTH-1:0]  req_tag_in;
  logic [NUM_REQS-1:0]            req_ready_in;

  // dcache request side
  logic                           req_valid_out;
  logic                           req_rw_out;
  logic [ADDR_WIDTH-1:0]          req_addr_out;
  logic [DATA_WIDTH-1:0]          req_data_out;
  logic [BE_W-1:0]                req_byteen_out;
  logic [TAG_WIDTH+SEL_W-1:0]     req_tag_out;
  logic                           req_ready_out;

  // dcache response side
  logic                           rsp_valid_in;
  logic [DATA_WIDTH-1:0]          rsp_data_in;
  logic [TAG_WIDTH+SEL_W-1:0]     rsp_tag_in;
  logic                           rsp_ready_in;

  // requester response side
  logic [NUM_REQS-1:0]            rsp_valid_out;
  logic [DATA_WIDTH-1:0]          rsp_data_out;
  logic [TAG_WIDTH-1:0]           rsp_tag_out;
  logic [NUM_REQS-1:0]            rsp_ready_out;

  // arbiter view
  modport slave (
    input  req_valid_in, req_rw_in, req_addr_in, req_data_in, req_byteen_in, req_tag_in,
    output req_ready_in,
    output req_valid_out, req_rw_out, req_addr_out, req_data_out, req_byteen_out, req_tag_out,
    input  req_ready_out,
    input  rsp_valid_in, rsp_data_in, rsp_tag_in,
    output rsp_ready_in,
    output rsp_valid_out, rsp_data_out, rsp_tag_out,
    input  rsp_ready_out
  );

  // environment view (requesters plus dcache)
  modport master (
    output req_valid_in, req_rw_in, req_addr_in, req_data_in, req_byteen_in, req_tag_in,
    input  req_ready_in,
    input  req_valid_out, req_rw_out, req_addr_out, req_data_out, req_byteen_out, req_tag_out,
    output req_ready_out,
    output rsp_valid_in, rsp_data_in, rsp_tag_in,
    input  rsp_ready_in,
    input  rsp_valid_out, rsp_data_out, rsp_tag_out,
    output rsp_ready_out
  );
endinterface

// File: rtl/vx_mem_req_arbiter.sv
// Round-robin arbiter sharing one dcache request port among NUM_REQS
// requesters. One registered output stage, requester index prepended to the
// outgoing tag, responses routed back by that index, and a per-requester cap
// on outstanding reads.
module vx_mem_req_arbiter #(
  parameter int NUM_REQS    = 4,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int TAG_WIDTH   = 8,
  parameter int MAX_PENDING = 4,
  localparam int SEL_W      = $clog2(NUM_REQS),
  localparam int CNT_W      = $clog2(MAX_PENDING + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  vx_mem_req_arbiter_if.slave       bus,
  output logic [NUM_REQS*CNT_W-1:0] pending_count,
  output logic                      busy
);
  localparam int BE_W = DATA_WIDTH / 8;

  // output stage
  logic                       valid_q;
  logic                       rw_q;
  logic [ADDR_WIDTH-1:0]      addr_q;
  logic [DATA_WIDTH-1:0]      data_q;
  logic [BE_W-1:0]            byteen_q;
  logic [TAG_WIDTH+SEL_W-1:0] tag_q;

  // arbitration state
  logic [SEL_W-1:0]           ptr_q, ptr_d;
  logic [CNT_W-1:0]           pend_q [NUM_REQS];
  logic [CNT_W-1:0]           pend_d [NUM_REQS];

  logic [NUM_REQS-1:0]        eligible;
  logic                       stage_free;
  logic                       grant_found;
  logic [SEL_W-1:0]           grant_idx;
  logic                       grant_fire;
  logic                       hi_found, lo_found;
  logic [SEL_W-1:0]           hi_idx, lo_idx;

  logic [SEL_W-1:0]           rsp_sel;
  logic                       rsp_fire;
  logic                       rsp_cnt_zero;
  logic                       any_pending;

  assign stage_free = !valid_q || bus.req_ready_out;
  assign rsp_sel    = bus.rsp_tag_in[TAG_WIDTH +: SEL_W];

  // Eligibility and round-robin pick: the first eligible index at or after
  // the pointer wins; otherwise wrap to the lowest eligible index.
  always_comb begin
    eligible = '0;
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      eligible[i] = bus.req_valid_in[i] &&
                    (bus.req_rw_in[i] || (pend_q[i] < CNT_W'(MAX_PENDING)));
    end
    for (int i = NUM_REQS - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        lo_found = 1'b1;
        lo_idx   = SEL_W'(i);
        if (SEL_W'(i) >= ptr_q) begin
          hi_found = 1'b1;
          hi_idx   = SEL_W'(i);
        end
      end
    end
    grant_found = hi_found || lo_found;
    grant_idx   = hi_found ? hi_idx : lo_idx;
    grant_fire  = grant_found && stage_free;
  end

  // Accept handshake back to the requesters: one-hot on the granted index.
  always_comb begin
    bus.req_ready_in = '0;
    if (grant_fire) begin
      bus.req_ready_in[grant_idx] = 1'b1;
    end
  end

  // Pointer advance: one past the last winner, wrapping at NUM_REQS.
  always_comb begin
    ptr_d = ptr_q;
    if (grant_fire) begin
      ptr_d = (grant_idx == SEL_W'(NUM_REQS - 1)) ? '0 : grant_idx + SEL_W'(1);
    end
  end

  // Response routing by the index carried in the top tag bits.
  always_comb begin
    bus.rsp_valid_out = '0;
    bus.rsp_ready_in  = 1'b0;
    rsp_cnt_zero      = 1'b0;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (rsp_sel == SEL_W'(i)) begin
        bus.rsp_valid_out[i] = bus.rsp_valid_in;
        bus.rsp_ready_in     = bus.rsp_ready_out[i];
        rsp_cnt_zero         = (pend_q[i] == '0);
      end
    end
    rsp_fire = bus.rsp_valid_in && bus.rsp_ready_in;
  end

  assign bus.rsp_data_out = bus.rsp_data_in;
  assign bus.rsp_tag_out  = bus.rsp_tag_in[TAG_WIDTH-1:0];

  // Outstanding-read counters: read grants count up, responses count down;
  // a simultaneous pair cancels. A response to an empty counter is ignored.
  always_comb begin
    any_pending = 1'b0;
    for (int i = 0; i < NUM_REQS; i++) begin
      logic inc;
      logic dec;
      inc = grant_fire && (grant_idx == SEL_W'(i)) && !bus.req_rw_in[i];
      dec = rsp_fire && (rsp_sel == SEL_W'(i)) && (pend_q[i] != '0);
      pend_d[i] = pend_q[i];
      if (inc && !dec) begin
        pend_d[i] = pend_q[i] + CNT_W'(1);
      end else if (dec && !inc) begin
        pend_d[i] = pend_q[i] - CNT_W'(1);
      end
      pending_count[i*CNT_W +: CNT_W] = pend_q[i];
      any_pending = any_pending || (pend_q[i] != '0);
    end
  end

  assign busy = valid_q || any_pending;

  // Control state: stage valid, round-robin pointer, read counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      ptr_q   <= '0;
      for (int i = 0; i < NUM_REQS; i++) begin
        pend_q[i] <= '0;
      end
    end else begin
      if (stage_free) begin
        valid_q <= grant_found;
      end
      ptr_q <= ptr_d;
      for (int i = 0; i < NUM_REQS; i++) begin
        pend_q[i] <= pend_d[i];
      end
    end
  end

  // Stage payload: loads only on a grant, otherwise holds.
  always_ff @(posedge clk) begin
    if (grant_fire) begin
      rw_q     <= bus.req_rw_in[grant_idx];
      addr_q   <= bus.req_addr_in[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
      data_q   <= bus.req_data_in[grant_idx*DATA_WIDTH +: DATA_WIDTH];
      byteen_q <= bus.req_byteen_in[grant_idx*BE_W +: BE_W];
      tag_q    <= {grant_idx, bus.req_tag_in[grant_idx*TAG_WIDTH +: TAG_WIDTH]};
    end
  end

  assign bus.req_valid_out  = valid_q;
  assign bus.req_rw_out     = rw_q;
  assign bus.req_addr_out   = addr_q;
  assign bus.req_data_out   = data_q;
  assign bus.req_byteen_out = byteen_q;
  assign bus.req_tag_out    = tag_q;

  a_rsp_sel_range: assert property (@(posedge clk) disable iff (reset)
    bus.rsp_valid_in |-> (int'(rsp_sel) < NUM_REQS));

  a_rsp_cnt_nonzero: assert property (@(posedge clk) disable iff (reset)
    rsp_fire |-> !rsp_cnt_zero);

endmodule

// File: tb/tb_vx_mem_req_arbiter.sv
// Directed bench for vx_mem_req_arbiter with hand-computed expectations.
module tb_vx_mem_req_arbiter;
  localparam int NR    = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int TW    = 8;
  localparam int MP    = 4;
  localparam int CW    = 3;
  localparam int BW    = DW / 8;

  logic clk;
  logic reset;
  logic [NR*CW-1:0] pending_count;
  logic busy;

  int checks = 0;
  int errors = 0;

  vx_mem_req_arbiter_if #(.NUM_REQS(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_WIDTH(TW)) bus ();

  vx_mem_req_arbiter #(
    .NUM_REQS(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_WIDTH(TW), .MAX_PENDING(MP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .pending_count(pending_count),
    .busy(busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    bus.req_valid_in  = '0;
    bus.req_rw_in     = '0;
    bus.req_addr_in   = '0;
    bus.req_data_in   = '0;
    bus.req_byteen_in = '0;
    bus.req_tag_in    = '0;
    bus.req_ready_out = 1'b0;
    bus.rsp_valid_in  = 1'b0;
    bus.rsp_data_in   = '0;
    bus.rsp_tag_in    = '0;
    bus.rsp_ready_out = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic drive_req(input int i, input logic v, input logic rw,
                           input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [BW-1:0] be, input logic [TW-1:0] t);
    bus.req_valid_in[i]          = v;
    bus.req_rw_in[i]             = rw;
    bus.req_addr_in[i*AW +: AW]  = a;
    bus.req_data_in[i*DW +: DW]  = d;
    bus.req_byteen_in[i*BW +: BW] = be;
    bus.req_tag_in[i*TW +: TW]   = t;
  endtask

  task automatic drive_rsp(input logic v, input logic [1:0] sel, input logic [TW-1:0] t,
                           input logic [DW-1:0] d, input logic [NR-1:0] rdy);
    bus.rsp_valid_in  = v;
    bus.rsp_tag_in    = {sel, t};
    bus.rsp_data_in   = d;
    bus.rsp_ready_out = rdy;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (bus.req_valid_out !== 1'b0) begin
      errors++; $display("FAIL reset_valid_out got %b expected 0", bus.req_valid_out);
    end
    checks++;
    if (pending_count !== '0) begin
      errors++; $display("FAIL reset_pending got %h expected 0", pending_count);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy got %b expected 0", busy);
    end
    checks++;
    if (bus.req_ready_in !== 4'b0000) begin
      errors++; $display("FAIL reset_ready_in got %b expected 0000", bus.req_ready_in);
    end
  endtask

  task automatic test_round_robin();
    logic [NR-1:0]   exp_rdy;
    logic [TW+1:0]   exp_tag;
    do_reset();
    for (int i = 0; i < NR; i++) drive_req(i, 1'b1, 1'b0, AW'(32'h1000 + i*4), '0, 4'hF, TW'(8'h10 + i));
    bus.req_ready_out = 1'b1;
    for (int n = 0; n < 18; n++) begin
      #1;
      exp_rdy = (n < 16) ? NR'(4'b0001 << (n % 4)) : 4'b0000;
      checks++;
      if (bus.req_ready_in !== exp_rdy) begin
        errors++; $display("FAIL rr_ready step %0d got %b expected %b", n, bus.req_ready_in, exp_rdy);
      end
      checks++;
      if (bus.req_valid_out !== ((n >= 1 && n <= 16) ? 1'b1 : 1'b0)) begin
        errors++; $display("FAIL rr_valid_out step %0d got %b", n, bus.req_valid_out);
      end
      if (n >= 1 && n <= 16) begin
        exp_tag = {2'((n - 1) % 4), TW'(8'h10 + (n - 1) % 4)};
        checks++;
        if (bus.req_tag_out !== exp_tag || bus.req_addr_out !== AW'(32'h1000 + ((n - 1) % 4) * 4)) begin
          errors++; $display("FAIL rr_payload step %0d got tag %h addr %h expected tag %h", n,
                             bus.req_tag_out, bus.req_addr_out, exp_tag);
        end
      end
      @(negedge clk);
    end
    #1;
    checks++;
    if (pending_count !== {4{3'd4}} || busy !== 1'b1) begin
      errors++; $display("FAIL rr_pending_full got %h busy %b expected %h busy 1", pending_count, busy, {4{3'd4}});
    end
  endtask

  task automatic test_limit();
    do_reset();
    drive_req(2, 1'b1, 1'b0, 32'h2000, '0, 4'hF, 8'h77);
    bus.req_ready_out = 1'b1;
    for (int n = 0; n < 6; n++) begin
      #1;
      checks++;
      if (bus.req_ready_in !== ((n < 4) ? 4'b0100 : 4'b0000)) begin
        errors++; $display("FAIL limit_ready step %0d got %b", n, bus.req_ready_in);
      end
      @(negedge clk);
    end
    drive_rsp(1'b1, 2'd2, 8'h33, 32'h0, 4'b0100);
    #1;
    checks++;
    if (bus.rsp_ready_in !== 1'b1 || bus.rsp_valid_out !== 4'b0100 || bus.req_ready_in !== 4'b0000) begin
      errors++; $display("FAIL limit_rsp got rsp_ready_in %b rsp_valid_out %b req_ready_in %b expected 1 0100 0000",
                         bus.rsp_ready_in, bus.rsp_valid_out, bus.req_ready_in);
    end
    @(negedge clk);
    drive_rsp(1'b0, 2'd0, 8'h00, 32'h0, 4'b0000);
    #1;
    checks++;
    if (bus.req_ready_in !== 4'b0100 || pending_count[2*CW +: CW] !== 3'd3) begin
      errors++; $display("FAIL limit_fifth got ready %b pend %0d expected 0100 3", bus.req_ready_in,
                         pending_count[2*CW +: CW]);
    end
    @(negedge clk);
    drive_req(2, 1'b0, 1'b0, '0, '0, '0, '0);
    #1;
    checks++;
    if (pending_count[2*CW +: CW] !== 3'd4 || bus.req_ready_in !== 4'b0000) begin
      errors++; $display("FAIL limit_refill got pend %0d ready %b expected 4 0000",
                         pending_count[2*CW +: CW], bus.req_ready_in);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    drive_req(0, 1'b1, 1'b0, 32'hA000, '0, 4'hF, 8'h21);
    drive_req(1, 1'b1, 1'b0, 32'hA100, '0, 4'hF, 8'h22);
    bus.req_ready_out = 1'b0;
    #1;
    checks++;
    if (bus.req_ready_in !== 4'b0001) begin
      errors++; $display("FAIL bp_first_grant got %b expected 0001", bus.req_ready_in);
    end
    @(negedge clk);
    drive_req(0, 1'b0, 1'b0, '0, '0, '0, '0);
    for (int n = 0; n < 3; n++) begin
      #1;
      checks++;
      if (bus.req_ready_in !== 4'b0000 || bus.req_valid_out !== 1'b1 ||
          bus.req_addr_out !== 32'hA000 || bus.req_tag_out !== {2'd0, 8'h21}) begin
        errors++; $display("FAIL bp_hold cycle %0d got ready %b valid %b addr %h tag %h", n,
                           bus.req_ready_in, bus.req_valid_out, bus.req_addr_out, bus.req_tag_out);
      end
      @(negedge clk);
    end
    bus.req_ready_out = 1'b1;
    #1;
    checks++;
    if (bus.req_ready_in !== 4'b0010 || bus.req_addr_out !== 32'hA000) begin
      errors++; $display("FAIL bp_release got ready %b addr %h expected 0010 a000", bus.req_ready_in, bus.req_addr_out);
    end
    @(negedge clk);
    drive_req(1, 1'b0, 1'b0, '0, '0, '0, '0);
    #1;
    checks++;
    if (bus.req_valid_out !== 1'b1 || bus.req_addr_out !== 32'hA100 || bus.req_tag_out !== {2'd1, 8'h22}) begin
      errors++; $display("FAIL bp_back_to_back got valid %b addr %h tag %h expected 1 a100 122",
                         bus.req_valid_out, bus.req_addr_out, bus.req_tag_out);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.req_valid_out !== 1'b0 || busy !== 1'b1 || pending_count !== {3'd0, 3'd0, 3'd1, 3'd1}) begin
      errors++; $display("FAIL bp_drain got valid %b busy %b pend %h", bus.req_valid_out, busy, pending_count);
    end
  endtask

  task automatic test_same_cycle();
    do_reset();
    drive_req(1, 1'b1, 1'b0, 32'hB000, '0, 4'hF, 8'h44);
    bus.req_ready_out = 1'b1;
    @(negedge clk);
    @(negedge clk);
    drive_rsp(1'b1, 2'd1, 8'h44, 32'h1234, 4'b0010);
    #1;
    checks++;
    if (pending_count[1*CW +: CW] !== 3'd2 || bus.req_ready_in !== 4'b0010 || bus.rsp_ready_in !== 1'b1) begin
      errors++; $display("FAIL same_setup got pend %0d ready %b rsp_ready %b expected 2 0010 1",
                         pending_count[1*CW +: CW], bus.req_ready_in, bus.rsp_ready_in);
    end
    @(negedge clk);
    clear_inputs();
    #1;
    checks++;
    if (pending_count[1*CW +: CW] !== 3'd2) begin
      errors++; $display("FAIL same_cycle_pend got %0d expected 2", pending_count[1*CW +: CW]);
    end
  endtask

  task automatic test_writes();
    do_reset();
    bus.req_ready_out = 1'b1;
    for (int n = 0; n < 11; n++) begin
      if (n < 10) drive_req(3, 1'b1, 1'b1, AW'(32'hC000 + n), DW'(32'hDEAD0000 + n), 4'hA, TW'(n));
      else        drive_req(3, 1'b0, 1'b0, '0, '0, '0, '0);
      #1;
      checks++;
      if (bus.req_ready_in !== ((n < 10) ? 4'b1000 : 4'b0000) || pending_count !== '0) begin
        errors++; $display("FAIL wr_accept step %0d got ready %b pend %h", n, bus.req_ready_in, pending_count);
      end
      if (n >= 1) begin
        checks++;
        if (bus.req_valid_out !== 1'b1 || bus.req_rw_out !== 1'b1 || bus.req_byteen_out !== 4'hA ||
            bus.req_data_out !== DW'(32'hDEAD0000 + n - 1) || bus.req_tag_out !== {2'd3, TW'(n - 1)}) begin
          errors++; $display("FAIL wr_payload step %0d got valid %b rw %b be %h data %h tag %h", n,
                             bus.req_valid_out, bus.req_rw_out, bus.req_byteen_out, bus.req_data_out, bus.req_tag_out);
        end
      end
      @(negedge clk);
    end
    #1;
    checks++;
    if (busy !== 1'b0 || bus.req_valid_out !== 1'b0) begin
      errors++; $display("FAIL wr_busy_drop got busy %b valid %b expected 0 0", busy, bus.req_valid_out);
    end
  endtask

  task automatic test_rsp_route();
    do_reset();
    drive_req(1, 1'b1, 1'b0, 32'hD000, '0, 4'hF, 8'h5A);
    bus.req_ready_out = 1'b1;
    @(negedge clk);
    drive_req(1, 1'b0, 1'b0, '0, '0, '0, '0);
    @(negedge clk);
    drive_rsp(1'b1, 2'd1, 8'h5A, 32'hCAFEF00D, 4'b0000);
    #1;
    checks++;
    if (bus.rsp_valid_out !== 4'b0010 || bus.rsp_ready_in !== 1'b0 || bus.rsp_tag_out !== 8'h5A) begin
      errors++; $display("FAIL rsp_blocked got valid %b ready %b tag %h expected 0010 0 5a",
                         bus.rsp_valid_out, bus.rsp_ready_in, bus.rsp_tag_out);
    end
    @(negedge clk);
    bus.rsp_ready_out = 4'b0010;
    #1;
    checks++;
    if (pending_count[1*CW +: CW] !== 3'd1 || bus.rsp_valid_out !== 4'b0010 || bus.rsp_ready_in !== 1'b1 ||
        bus.rsp_tag_out !== 8'h5A || bus.rsp_data_out !== 32'hCAFEF00D) begin
      errors++; $display("FAIL rsp_route got pend %0d valid %b ready %b tag %h data %h",
                         pending_count[1*CW +: CW], bus.rsp_valid_out, bus.rsp_ready_in,
                         bus.rsp_tag_out, bus.rsp_data_out);
    end
    @(negedge clk);
    clear_inputs();
    #1;
    checks++;
    if (pending_count !== '0 || bus.rsp_valid_out !== 4'b0000 || busy !== 1'b0) begin
      errors++; $display("FAIL rsp_done got pend %h valid %b busy %b expected 0 0000 0",
                         pending_count, bus.rsp_valid_out, busy);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_limit();
    test_backpressure();
    test_same_cycle();
    test_writes();
    test_rsp_route();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
